// File: rtl/dw_ram_2r_w_fifoctl_pkg.sv
// Shared encodings for the dual-read-port RAM FIFO controller.
package dw_ram_2r_w_fifoctl_pkg;

    localparam logic [1:0] POP_NONE = 2'd0;
    localparam logic [1:0] POP_ONE  = 2'd1;
    localparam logic [1:0] POP_TWO  = 2'd2;

    localparam int ERR_STICKY = 0;
    localparam int ERR_PULSE  = 1;

    // Per-cycle request decision.
    typedef struct packed {
        logic       push_ok;
        logic       pop_ok;
        logic [1:0] pop_amt;
        logic       illegal;
    } fifo_req_t;

    function automatic logic pop_legal(input logic [1:0] pop_cnt);
        return (pop_cnt == POP_ONE) || (pop_cnt == POP_TWO);
    endfunction

endpackage

// File: rtl/dw_ram_2r_w_fifoctl_ptr_wrap.sv
// Modulo-depth pointer advance by 0, 1 or 2; correct for non-power-of-2 depths.
module dw_fifoctl_ptr_wrap #(
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic [addr_width-1:0] ptr,
    input  logic [1:0]            inc,
    output logic [addr_width-1:0] ptr_nxt
);

    localparam logic [addr_width:0] DEPTH_W = (addr_width+1)'(depth);

    logic [addr_width:0] sum;

    // One extra bit holds ptr+inc; a single subtract suffices since inc <= depth.
    always_comb begin
        sum     = {1'b0, ptr} + (addr_width+1)'(inc);
        ptr_nxt = (sum >= DEPTH_W) ? addr_width'(sum - DEPTH_W) : addr_width'(sum);
    end

endmodule

// File: rtl/dw_ram_2r_w_fifoctl.sv
// FIFO controller for a 2-read/1-write RAM: pops 0..2 entries per cycle, one push.
module dw_ram_2r_w_fifoctl
    import dw_ram_2r_w_fifoctl_pkg::*;
#(
    parameter int depth      = 8,
    parameter int addr_width = 3,
    parameter int ae_level   = 1,
    parameter int af_level   = 1,
    parameter int err_mode   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [1:0]            pop_cnt,
    output logic [addr_width:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  valid2,
    output logic                  error,
    output logic                  ram_cs_n,
    output logic                  ram_wr_n,
    output logic [addr_width-1:0] ram_wr_addr,
    output logic [addr_width-1:0] ram_rd1_addr,
    output logic [addr_width-1:0] ram_rd2_addr
);

    localparam logic [addr_width:0] DEPTH_W = (addr_width+1)'(depth);
    localparam logic [addr_width:0] AE_THR  = (addr_width+1)'(ae_level);
    localparam logic [addr_width:0] AF_THR  = (addr_width+1)'(depth - af_level);

    logic [addr_width-1:0] rd_ptr, wr_ptr;
    logic [addr_width-1:0] rd_ptr_nxt, wr_ptr_nxt, rd2_addr;
    logic [addr_width:0]   count_r, count_nxt;
    logic                  error_r;
    fifo_req_t             req;

    // Pop is judged against pre-push occupancy; a full FIFO still takes a push
    // when a pop frees space in the same cycle.
    always_comb begin
        req         = '0;
        req.pop_ok  = pop_legal(pop_cnt) && ((addr_width+1)'(pop_cnt) <= count_r);
        req.push_ok = push && ((count_r != DEPTH_W) || req.pop_ok);
        req.pop_amt = req.pop_ok ? pop_cnt : POP_NONE;
        req.illegal = (push && !req.push_ok) || ((pop_cnt != POP_NONE) && !req.pop_ok);
        count_nxt   = count_r + (addr_width+1)'(req.push_ok) - (addr_width+1)'(req.pop_amt);
    end

    dw_fifoctl_ptr_wrap #(.depth(depth), .addr_width(addr_width)) u_rd_wrap (
        .ptr     (rd_ptr),
        .inc     (req.pop_amt),
        .ptr_nxt (rd_ptr_nxt)
    );

    dw_fifoctl_ptr_wrap #(.depth(depth), .addr_width(addr_width)) u_wr_wrap (
        .ptr     (wr_ptr),
        .inc     ({1'b0, req.push_ok}),
        .ptr_nxt (wr_ptr_nxt)
    );

    // Next-entry read address, so head and head+1 are both visible this cycle.
    dw_fifoctl_ptr_wrap #(.depth(depth), .addr_width(addr_width)) u_rd2_wrap (
        .ptr     (rd_ptr),
        .inc     (POP_ONE),
        .ptr_nxt (rd2_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
            error_r <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            wr_ptr  <= wr_ptr_nxt;
            count_r <= count_nxt;
            if (err_mode == ERR_PULSE)
                error_r <= req.illegal;
            else
                error_r <= error_r | req.illegal;
        end
    end

    always_comb begin
        count        = count_r;
        empty        = (count_r == '0);
        full         = (count_r == DEPTH_W);
        almost_empty = (count_r <= AE_THR);
        almost_full  = (count_r >= AF_THR);
        valid2       = (count_r >= (addr_width+1)'(2));
        error        = error_r;
        ram_cs_n     = ~(req.push_ok & ~rst);
        ram_wr_n     = ~(req.push_ok & ~rst);
        ram_wr_addr  = wr_ptr;
        ram_rd1_addr = rd_ptr;
        ram_rd2_addr = rd2_addr;
    end

endmodule

// File: tb/tb_dw_ram_2r_w_fifoctl.sv
// Bench: three controllers (depth 8 sticky, depth 8 pulse, depth 5 sticky) on shared inputs.
module tb_dw_ram_2r_w_fifoctl;

    localparam int ND = 3;
    localparam int DEP [ND] = '{8, 8, 5};
    localparam int EM  [ND] = '{0, 1, 0};
    localparam int AE  [ND] = '{1, 1, 2};
    localparam int AF  [ND] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst, push;
    logic [1:0] pop_cnt;

    logic [3:0] count_w [ND];
    logic [2:0] wa_w [ND], r1_w [ND], r2_w [ND];
    logic       empty_w [ND], full_w [ND], ae_w [ND], af_w [ND], v2_w [ND];
    logic       err_w [ND], cs_w [ND], wrn_w [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dw_ram_2r_w_fifoctl #(
            .depth(DEP[g]), .addr_width(3), .ae_level(AE[g]),
            .af_level(AF[g]), .err_mode(EM[g])
        ) u_dut (
            .clk(clk), .rst(rst), .push(push), .pop_cnt(pop_cnt),
            .count(count_w[g]), .empty(empty_w[g]), .full(full_w[g]),
            .almost_empty(ae_w[g]), .almost_full(af_w[g]), .valid2(v2_w[g]),
            .error(err_w[g]), .ram_cs_n(cs_w[g]), .ram_wr_n(wrn_w[g]),
            .ram_wr_addr(wa_w[g]), .ram_rd1_addr(r1_w[g]), .ram_rd2_addr(r2_w[g])
        );
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: occupancy and head/tail as plain integers modulo depth.
    int m_cnt [ND], m_rd [ND], m_wr [ND];
    bit m_err [ND];

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_cnt[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_err[i] = 0;
        end
    endtask

    // Drive one cycle, check all DUTs against the model before the edge, then advance.
    task automatic apply(input bit p, input int pc, input bit r);
        bit pa [ND];
        int pn [ND];
        bit bad [ND];
        push = p; pop_cnt = 2'(pc); rst = r;
        #1;
        for (int i = 0; i < ND; i++) begin
            bit pop_ok;
            pop_ok = (pc == 1 || pc == 2) && pc <= m_cnt[i];
            pa[i]  = p && (m_cnt[i] < DEP[i] || pop_ok);
            pn[i]  = pop_ok ? pc : 0;
            bad[i] = (p && !pa[i]) || (pc != 0 && !pop_ok);
            chk($sformatf("d%0d count", i), int'(count_w[i]), m_cnt[i]);
            chk($sformatf("d%0d empty", i), int'(empty_w[i]), int'(m_cnt[i] == 0));
            chk($sformatf("d%0d full", i), int'(full_w[i]), int'(m_cnt[i] == DEP[i]));
            chk($sformatf("d%0d almost_empty", i), int'(ae_w[i]), int'(m_cnt[i] <= AE[i]));
            chk($sformatf("d%0d almost_full", i), int'(af_w[i]), int'(m_cnt[i] >= DEP[i] - AF[i]));
            chk($sformatf("d%0d valid2", i), int'(v2_w[i]), int'(m_cnt[i] >= 2));
            chk($sformatf("d%0d error", i), int'(err_w[i]), int'(m_err[i]));
            chk($sformatf("d%0d rd1", i), int'(r1_w[i]), m_rd[i]);
            chk($sformatf("d%0d rd2", i), int'(r2_w[i]), (m_rd[i] + 1) % DEP[i]);
            chk($sformatf("d%0d wr_addr", i), int'(wa_w[i]), m_wr[i]);
            chk($sformatf("d%0d cs_n", i), int'(cs_w[i]), int'(!(pa[i] && !r)));
            chk($sformatf("d%0d wr_n", i), int'(wrn_w[i]), int'(!(pa[i] && !r)));
        end
        @(posedge clk); #1;
        for (int i = 0; i < ND; i++) begin
            if (r) begin
                m_cnt[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_err[i] = 0;
            end else begin
                m_wr[i]  = (m_wr[i] + int'(pa[i])) % DEP[i];
                m_rd[i]  = (m_rd[i] + pn[i]) % DEP[i];
                m_cnt[i] = m_cnt[i] + int'(pa[i]) - pn[i];
                m_err[i] = (EM[i] == 1) ? bad[i] : (m_err[i] | bad[i]);
            end
        end
    endtask

    typedef struct {
        bit p; int pc; bit r;
        int cnt; int rd; int wr; int e0; int e1;
    } vec_t;
    vec_t vecs [$];

    task automatic add(input bit p, input int pc, input bit r, input int cnt,
                       input int rd, input int wr, input int e0, input int e1);
        vec_t v;
        v.p = p; v.pc = pc; v.r = r; v.cnt = cnt; v.rd = rd; v.wr = wr; v.e0 = e0; v.e1 = e1;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop_cnt = 2'd0;
        @(posedge clk); #1;
        model_reset();

        // Expected post-edge state for the depth-8 units.
        add(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(1, 0, 0, k, 0, k % 8, 0, 0);
        add(1, 1, 0, 8, 1, 1, 0, 0);
        add(0, 2, 0, 6, 3, 1, 0, 0);
        add(0, 2, 0, 4, 5, 1, 0, 0);
        add(0, 1, 0, 3, 6, 1, 0, 0);
        add(0, 2, 0, 1, 0, 1, 0, 0);
        add(0, 2, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 3, 0, 1, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        foreach (vecs[n]) begin
            apply(vecs[n].p, vecs[n].pc, vecs[n].r);
            chk($sformatf("vec%0d count", n), int'(count_w[0]), vecs[n].cnt);
            chk($sformatf("vec%0d rd1", n), int'(r1_w[0]), vecs[n].rd);
            chk($sformatf("vec%0d wr_addr", n), int'(wa_w[0]), vecs[n].wr);
            chk($sformatf("vec%0d almost_full", n), int'(af_w[0]), int'(vecs[n].cnt >= 7));
            chk($sformatf("vec%0d err_sticky", n), int'(err_w[0]), vecs[n].e0);
            chk($sformatf("vec%0d err_pulse", n), int'(err_w[1]), vecs[n].e1);
        end

        // Full with rd_ptr = wr_ptr = 3: simultaneous push and pop.
        apply(0, 0, 1);
        for (int k = 0; k < 3; k++) apply(1, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 1, 0);
        for (int k = 0; k < 8; k++) apply(1, 0, 0);
        chk("full33 pre count", int'(count_w[0]), 8);
        chk("full33 pre rd1", int'(r1_w[0]), 3);
        push = 1'b1; pop_cnt = 2'd1; #1;
        chk("full33 wr_n", int'(wrn_w[0]), 0);
        chk("full33 wr_addr", int'(wa_w[0]), 3);
        apply(1, 1, 0);
        chk("full33 count", int'(count_w[0]), 8);
        chk("full33 rd1", int'(r1_w[0]), 4);
        chk("full33 wr_addr post", int'(wa_w[0]), 4);
        chk("full33 error", int'(err_w[0]), 0);

        // Empty: push accepted, pop rejected.
        apply(0, 0, 1);
        apply(1, 1, 0);
        chk("emptypp count", int'(count_w[0]), 1);
        chk("emptypp error", int'(err_w[0]), 1);

        // Mid-operation reset with push held.
        apply(0, 0, 1);
        for (int k = 0; k < 5; k++) apply(1, 0, 0);
        chk("rstmid pre count", int'(count_w[0]), 5);
        rst = 1'b1; push = 1'b1; pop_cnt = 2'd0; #1;
        chk("rstmid cs_n", int'(cs_w[0]), 1);
        apply(1, 0, 1);
        chk("rstmid count", int'(count_w[0]), 0);
        chk("rstmid rd1", int'(r1_w[0]), 0);
        chk("rstmid wr_addr", int'(wa_w[0]), 0);
        chk("rstmid empty", int'(empty_w[0]), 1);
        chk("rstmid error", int'(err_w[0]), 0);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases.
        for (int c = 0; c < 800; c++) begin
            int pp, rr;
            bit p, r;
            int pc;
            pp = ((c / 60) % 2 == 0) ? 75 : 30;
            p  = ($urandom_range(0, 99) < pp);
            rr = $urandom_range(0, 15);
            pc = (rr < 5) ? 0 : (rr < 11) ? 1 : (rr < 15) ? 2 : 3;
            r  = ($urandom_range(0, 149) == 0);
            apply(p, pc, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dw_ram_2r_w_fifoctl.md
DW_RAM_2R_W_FIFOCTL -- requirements
Module: dw_ram_2r_w_fifoctl

Interface
REQ-001 SHALL have parameter depth, default 8, number of RAM words, legal range 2..256.
REQ-002 SHALL have parameter addr_width, default 3, equal to ceil(log2(depth)).
REQ-003 SHALL have parameter ae_level, default 1, almost-empty threshold, legal range 1..depth-1.
REQ-004 SHALL have parameter af_level, default 1, almost-full threshold, legal range 1..depth-1.
REQ-005 SHALL have parameter err_mode, default 0: 0 = sticky error, 1 = single-cycle error.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port push, input, 1 bit: write request, active-high.
REQ-009 SHALL have port pop_cnt, input, 2 bits: number of entries to pop (0, 1 or 2); 3 is illegal.
REQ-010 SHALL have port count, output, addr_width+1 bits: current occupancy.
REQ-011 SHALL have ports empty, full, almost_empty, almost_full and valid2, each output, 1 bit; valid2 means count >= 2.
REQ-012 SHALL have port error, output, 1 bit: illegal-request flag.
REQ-013 SHALL have ports ram_cs_n and ram_wr_n, each output, 1 bit: active-low RAM chip-select and write-enable.
REQ-014 SHALL have ports ram_wr_addr, ram_rd1_addr and ram_rd2_addr, each output, addr_width bits.

Function
REQ-015 SHALL keep three registers: rd_ptr, wr_ptr and count.
- Each pointer increment SHALL wrap from depth-1 to 0, including for non-power-of-2 depth.
REQ-016 SHALL drive ram_rd1_addr = rd_ptr and ram_rd2_addr = (rd_ptr+1) mod depth, combinationally from registers.
- Head and next entry are therefore visible in the same cycle, because the RAM reads asynchronously.
REQ-017 SHALL drive ram_wr_addr = wr_ptr.
REQ-018 SHALL accept a pop when 1 <= pop_cnt <= count, using count before this cycle's push.
- Otherwise the whole pop SHALL be rejected; there is no partial pop.
REQ-019 SHALL accept a push when push=1 and either count < depth, or the pop is accepted in the same cycle.
REQ-020 SHALL drive ram_cs_n = ram_wr_n = 0 only in a cycle with an accepted push and rst=0; both SHALL be 1 otherwise.
REQ-021 On each edge with rst=0, SHALL update pointers and count as follows:
- wr_ptr += 1 on an accepted push.
- rd_ptr += pop_cnt on an accepted pop.
- count += (accepted push) - (accepted pop_cnt).
REQ-022 SHALL handle a push with pop when full by writing at wr_ptr (equal to rd_ptr) at the edge; count SHALL stay at depth - pop_cnt + 1.
REQ-023 SHALL derive the status flags combinationally from count:
- empty = (count==0)
- full = (count==depth)
- almost_empty = (count<=ae_level)
- almost_full = (count>=depth-af_level)
REQ-024 SHALL treat as illegal: push rejected; pop rejected with pop_cnt != 0; pop_cnt == 3.
REQ-025 SHALL register error on the edge after an illegal request.
- err_mode 0: error SHALL stay 1 until rst.
- err_mode 1: error SHALL be 1 for exactly one cycle per illegal cycle.
REQ-026 SHALL leave state unchanged by rejected requests, apart from error.

Reset
REQ-027 On a clock edge with rst=1, SHALL set rd_ptr=0, wr_ptr=0, count=0 and error=0.
- Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0, valid2=0, ram addresses=0.
REQ-028 While rst=1, SHALL hold ram_cs_n=1 and ram_wr_n=1 and ignore push and pop_cnt.
- This applies even mid-operation; RAM contents are not cleared.

Structure
REQ-029 SHALL place in a shared package: the pop_cnt encoding constants (POP_NONE=0, POP_ONE=1, POP_TWO=2) and the err_mode constants (ERR_STICKY=0, ERR_PULSE=1).
REQ-030 SHALL implement the modulo-depth pointer advance (by 1 or 2) in one sub-module, dw_fifoctl_ptr_wrap, instantiated for rd_ptr and wr_ptr.
REQ-031 SHALL contain no data path; data flows directly between the user and DW_ram_2r_w_s_dff.

Verification (depth=8, ae_level=1, af_level=1, err_mode=0 unless noted)
REQ-032 Reset, then push=1 for 8 cycles:
- ram_wr_addr steps 0..7.
- almost_full rises when count=7.
- Afterwards count=8, full=1, wr_ptr=0.
REQ-033 With count=3 and rd_ptr=6, pop_cnt=2:
- In that cycle, rd1_addr=6 and rd2_addr=7.
- Next cycle: rd_ptr=0, rd1_addr=0, rd2_addr=1, count=1, valid2=0.
REQ-034 With count=1, pop_cnt=2:
- Rejected; count stays 1; error=1 next cycle and stays 1.
- Repeat with err_mode=1: error is a one-cycle pulse.
REQ-035 With full (count=8, rd_ptr=wr_ptr=3), push=1 and pop_cnt=1:
- ram_wr_n=0 with ram_wr_addr=3.
- Next cycle: count=8, rd_ptr=4, wr_ptr=4, error=0.
REQ-036 With empty, push=1 and pop_cnt=1:
- Push accepted, pop rejected.
- Next cycle: count=1, error=1.
REQ-037 With count=5, assert rst for one cycle with push=1:
- ram_cs_n=1 throughout.
- Next cycle: count=0, pointers 0, empty=1, error=0.
